// File: rtl/image_conv_shift_pkg.sv
// Shared widths and latency for the accumulator requantisation path.
// Holds the Para.v macros so every file of the slice sees one definition.
`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif
`ifndef WIDTH_ACC
`define WIDTH_ACC 32
`endif
`ifndef WIDTH_SCALE
`define WIDTH_SCALE 32
`endif
`ifndef WIDTH_SHIFT
`define WIDTH_SHIFT 6
`endif
`ifndef SHIFT_LATENCY
`define SHIFT_LATENCY 4
`endif

package image_conv_shift_pkg;
  localparam int PICTURE_NUM   = `PICTURE_NUM;
  localparam int WIDTH_DATA    = `WIDTH_DATA;
  localparam int WIDTH_ACC     = `WIDTH_ACC;
  localparam int WIDTH_SCALE   = `WIDTH_SCALE;
  localparam int WIDTH_SHIFT   = `WIDTH_SHIFT;
  localparam int SHIFT_LATENCY = `SHIFT_LATENCY;
  localparam int WIDTH_OUT     = 2 * WIDTH_DATA;
  localparam int WIDTH_SUM     = WIDTH_ACC + 1;
  localparam int WIDTH_PROD    = WIDTH_SUM + WIDTH_SCALE;
  localparam int WIDTH_RND     = WIDTH_PROD + 1;
endpackage

// File: rtl/image_shift_lane.sv
// One requantisation lane: bias add, multiply, round-shift, saturate.
// Each stage loads only when the shared valid pipeline says its input is live.
module image_shift_lane
  import image_conv_shift_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SHIFT_LATENCY-1:0]      stage_en,
  input  logic signed [WIDTH_ACC-1:0]   acc,
  input  logic signed [WIDTH_ACC-1:0]   bias,
  input  logic [WIDTH_SCALE-1:0]        scale,
  input  logic [WIDTH_SHIFT-1:0]        shift,
  output logic [WIDTH_OUT-1:0]          data_out
);

  logic signed [WIDTH_SUM-1:0]  sum_q;
  logic signed [WIDTH_PROD-1:0] prod_q;
  logic signed [WIDTH_RND-1:0]  shifted_q;
  logic signed [WIDTH_RND-1:0]  round_add;
  logic signed [WIDTH_RND-1:0]  shifted_d;
  logic [WIDTH_OUT-1:0]         sat_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    round_add = '0;
    if (shift != '0)
      round_add = WIDTH_RND'(1) <<< (shift - WIDTH_SHIFT'(1));
    shifted_d = (WIDTH_RND'(prod_q) + round_add) >>> shift;
  end

  // Clamp on the full-width shifted value so large products cannot wrap into range.
  always_comb begin
    sat_d = shifted_q[WIDTH_OUT-1:0];
    if (shifted_q > WIDTH_RND'(32767))
      sat_d = 16'h7FFF;
    else if (shifted_q < -WIDTH_RND'(32768))
      sat_d = 16'h8000;
  end

  // NOTE: datapath stages carry no reset; the shared valid pipeline decides what is live.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (stage_en[0]) sum_q     <= WIDTH_SUM'(acc) + WIDTH_SUM'(bias);
    if (stage_en[1]) prod_q    <= WIDTH_PROD'(sum_q) * WIDTH_PROD'($signed({1'b0, scale}));
    if (stage_en[2]) shifted_q <= shifted_d;
  end

  always_ff @(posedge clk) begin
    if (rst)
      data_out <= '0;
    else if (stage_en[3])
      data_out <= sat_d;
  end

endmodule

// File: rtl/image_conv_shift.sv
// Requantises N accumulator lanes to signed 16-bit with per-channel bias,
// shared scale/shift, frame beat counting and guarded parameter loading.
module image_conv_shift
  import image_conv_shift_pkg::*;
#(
  parameter int CHANNEL_OUT_NUM = 8
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            valid_in,
  input  logic [`PICTURE_NUM*CHANNEL_OUT_NUM*32-1:0]      acc_data_in,
  input  logic                                            param_load,
  input  logic [CHANNEL_OUT_NUM*32-1:0]                   bias_in,
  input  logic [31:0]                                     scale_in,
  input  logic [5:0]                                      shift_in,
  input  logic [15:0]                                     frame_pixels_in,
  output logic                                            valid_out,
  output logic [`PICTURE_NUM*CHANNEL_OUT_NUM*2*`WIDTH_DATA-1:0] shift_data_out,
  output logic                                            frame_done,
  output logic                                            param_err
);

  localparam int LANES = PICTURE_NUM * CHANNEL_OUT_NUM;

  logic [CHANNEL_OUT_NUM*32-1:0] bias_q;
  logic [WIDTH_SCALE-1:0]        scale_q;
  logic [WIDTH_SHIFT-1:0]        shift_q;
  logic [15:0]                   frame_pixels_q;
  logic [15:0]                   beat_cnt;
  logic [SHIFT_LATENCY-2:0]      stage_v;
  logic                          idle;

  // Parameters may only change with nothing in flight, so every beat sees one consistent set.
  assign idle = !valid_in && !(|stage_v) && !valid_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_v        <= '0;
      valid_out      <= 1'b0;
      frame_done     <= 1'b0;
      param_err      <= 1'b0;
      beat_cnt       <= '0;
      bias_q         <= '0;
      scale_q        <= '0;
      shift_q        <= '0;
      frame_pixels_q <= '0;
    end else begin
      stage_v    <= {stage_v[SHIFT_LATENCY-3:0], valid_in};
      valid_out  <= stage_v[SHIFT_LATENCY-2];
      frame_done <= 1'b0;

      if (param_load) begin
        if (idle) begin
          bias_q         <= bias_in;
          scale_q        <= scale_in;
          shift_q        <= shift_in;
          frame_pixels_q <= frame_pixels_in;
          beat_cnt       <= '0;
        end else begin
          param_err <= 1'b1;
        end
      end

      // Counting at the last stage aligns frame_done with its beat; 0 wraps to 65536 beats.
      if (stage_v[SHIFT_LATENCY-2]) begin
        if (beat_cnt == frame_pixels_q - 16'd1) begin
          frame_done <= 1'b1;
          beat_cnt   <= '0;
        end else begin
          beat_cnt <= beat_cnt + 16'd1;
        end
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    image_shift_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .stage_en ({stage_v, valid_in}),
      .acc      (acc_data_in[k*32 +: 32]),
      .bias     (bias_q[(k/PICTURE_NUM)*32 +: 32]),
      .scale    (scale_q),
      .shift    (shift_q),
      .data_out (shift_data_out[k*WIDTH_OUT +: WIDTH_OUT])
    );
  end

endmodule
